// File: rtl/skip_pkg.sv
// Shared constants for the skip-clock transmit and receive blocks.
// Holds the default pattern length and the counter width helper.
package skip_pkg;

    localparam int LEN_DEF = 16;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/skip_sync.sv
// N-stage synchronizer with a previous-value register and edge outputs.
// Edges stay masked until the chain and previous register hold real samples.
module skip_sync
    import skip_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;
    logic         prev_q;
    logic         prev_d;
    logic [N:0]   vld_q;
    logic [N:0]   vld_d;

    // Next-state for the synchronizer chain, previous value and warm-up mask.
    always_comb begin
        sync_d = {sync_q[N-2:0], d};
        prev_d = sync_q[N-1];
        vld_d  = {vld_q[N-1:0], 1'b1};
    end

    // Synchronizer, previous-value and warm-up registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {N{1'b0}};
            prev_q <= 1'b0;
            vld_q  <= {(N + 1){1'b0}};
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            vld_q  <= vld_d;
        end
    end

    assign q    = sync_q[N-1];
    assign rise = vld_q[N] &  sync_q[N-1] & ~prev_q;
    assign fall = vld_q[N] & ~sync_q[N-1] &  prev_q;

endmodule

// File: rtl/skip_decoder.sv
// Decodes one mask bit per reference-clock period from iCLK/iSCLK and
// tracks whether the decoded stream repeats with period LEN.
module skip_decoder
    import skip_pkg::*;
#(
    parameter int LEN      = LEN_DEF,
    parameter int LOCK_CNT = 4,
    parameter int SYNC     = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    iCLK,
    input  logic                    iSCLK,
    output logic                    oVALID,
    output logic                    oBIT,
    output logic [LEN-1:0]          oMASK,
    output logic [$clog2(LEN)-1:0]  oPHASE,
    output logic                    oLOCK,
    output logic                    oERR
);

    localparam int PW = $clog2(LEN);
    localparam int MW = cnt_w(LOCK_CNT * LEN);
    localparam int IW = cnt_w(TIMEOUT);
    localparam int FW = cnt_w(LEN);

    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT * LEN);
    localparam logic [MW-1:0] MATCH_PRE = MW'(LOCK_CNT * LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(LEN);
    localparam logic [PW-1:0] PHASE_MAX = PW'(LEN - 1);

    logic clk_s, clk_rise, clk_fall;
    logic sclk_s, sclk_rise, sclk_fall;

    skip_sync #(.N(SYNC)) u_sync_clk (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (iCLK),
        .q     (clk_s),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    skip_sync #(.N(SYNC)) u_sync_sclk (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (iSCLK),
        .q     (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    logic           armed_q, armed_d;
    logic           seen_q, seen_d;
    logic           valid_q, valid_d;
    logic           bit_q, bit_d;
    logic           err_q, err_d;
    logic           lock_q, lock_d;
    logic [LEN-1:0] mask_q, mask_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic [MW-1:0]  match_q, match_d;
    logic [IW-1:0]  idle_q, idle_d;

    logic decode_s, dec_bit_s, cmp_en_s, match_s;

    // Decode, pattern compare, lock tracking and idle timeout.
    always_comb begin
        // A fall only counts once a full high phase has been seen since reset.
        decode_s  = clk_fall & armed_q;
        // sclk edge terms absorb a one-cycle skew between the two synchronizers.
        dec_bit_s = seen_q | sclk_s | sclk_fall;
        cmp_en_s  = (fill_q == FILL_MAX);
        match_s   = (dec_bit_s == mask_q[LEN-1]);

        armed_d = armed_q | clk_rise;
        seen_d  = clk_fall ? 1'b0 : (seen_q | (clk_s & sclk_s) | sclk_rise);
        valid_d = 1'b0;
        bit_d   = bit_q;
        err_d   = 1'b0;
        lock_d  = lock_q;
        mask_d  = mask_q;
        phase_d = phase_q;
        fill_d  = fill_q;
        match_d = match_q;
        idle_d  = idle_q;

        if (decode_s) begin
            valid_d = 1'b1;
            bit_d   = dec_bit_s;
            mask_d  = {mask_q[LEN-2:0], dec_bit_s};
            phase_d = (phase_q == PHASE_MAX) ? PW'(0) : phase_q + PW'(1);
            idle_d  = IW'(0);
            if (!cmp_en_s) begin
                fill_d = fill_q + FW'(1);
            end else if (match_s) begin
                if (match_q != MATCH_MAX) begin
                    match_d = match_q + MW'(1);
                end else begin
                    match_d = match_q;
                end
                lock_d = lock_q | (match_q >= MATCH_PRE);
            end else begin
                match_d = MW'(0);
                lock_d  = 1'b0;
                err_d   = lock_q;
            end
        end else if (idle_q == IDLE_LAST) begin
            idle_d  = IDLE_MAX;
            lock_d  = 1'b0;
            match_d = MW'(0);
            fill_d  = FW'(0);
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IW'(1);
        end else begin
            idle_d = idle_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed_q <= 1'b0;
            seen_q  <= 1'b0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
            mask_q  <= {LEN{1'b0}};
            phase_q <= {PW{1'b0}};
            fill_q  <= {FW{1'b0}};
            match_q <= {MW{1'b0}};
            idle_q  <= {IW{1'b0}};
        end else begin
            armed_q <= armed_d;
            seen_q  <= seen_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
            mask_q  <= mask_d;
            phase_q <= phase_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            idle_q  <= idle_d;
        end
    end

    assign oVALID = valid_q;
    assign oBIT   = bit_q;
    assign oMASK  = mask_q;
    assign oPHASE = phase_q;
    assign oLOCK  = lock_q;
    assign oERR   = err_q;

endmodule

// File: tb/tb_skip_decoder.sv
// Randomized-timing bench for skip_decoder against a history-based reference model.
module tb_skip_decoder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        iCLK = 1'b0;
    logic        iSCLK = 1'b0;
    logic        oVALID, oBIT, oLOCK, oERR;
    logic [15:0] oMASK;
    logic [3:0]  oPHASE;

    skip_decoder dut (
        .CLK(CLK), .RST_N(RST_N), .iCLK(iCLK), .iSCLK(iSCLK),
        .oVALID(oVALID), .oBIT(oBIT), .oMASK(oMASK), .oPHASE(oPHASE),
        .oLOCK(oLOCK), .oERR(oERR)
    );

    always #5 CLK = ~CLK;

    int vec = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    localparam logic [15:0] PAT = 16'h3445;
    int pk = 0;

    // observations from the most recent pulse
    int          obs_vcnt, obs_ecnt, obs_vcyc;
    logic        obs_bit, obs_lock, obs_err;
    logic [15:0] obs_mask;
    logic [3:0]  obs_phase;

    // reference model: full decoded history since reset, restart point of fill
    bit          hist[$];
    int          rs = 0;
    bit          m_lock = 1'b0;
    bit          e_bit, e_lock, e_err;
    logic [15:0] e_mask;
    logic [3:0]  e_phase;

    task automatic model_reset();
        hist.delete();
        rs = 0;
        m_lock = 1'b0;
    endtask

    task automatic model_timeout();
        rs = hist.size();
        m_lock = 1'b0;
    endtask

    // Lock holds iff the last 64 decodes each repeat the bit 16 earlier, all after fill.
    task automatic model_decode(input bit b);
        int idx;
        bit win;
        hist.push_back(b);
        idx = hist.size() - 1;
        e_bit = b;
        e_mask = 16'h0000;
        for (int k = 0; k < 16; k++)
            if (idx - k >= 0) e_mask[k] = hist[idx - k];
        e_phase = 4'(hist.size() % 16);
        e_err = m_lock && (idx - rs >= 16) && (hist[idx] != hist[idx - 16]);
        win = (idx - rs >= 79);
        if (win)
            for (int j = idx - 63; j <= idx; j++)
                if (hist[j] != hist[j - 16]) win = 1'b0;
        m_lock = win;
        e_lock = win;
    endtask

    function automatic bit pat_bit(input int k);
        logic [15:0] p;
        p = PAT;
        return p[15 - (k % 16)];
    endfunction

    task automatic do_pulse(input bit b);
        int hi, lo;
        hi = $urandom_range(4, 7);
        lo = $urandom_range(5, 8);
        obs_vcnt = 0;
        obs_ecnt = 0;
        iCLK = 1'b1;
        iSCLK = b;
        for (int i = 0; i < hi + lo; i++) begin
            if (i == hi) begin
                iCLK = 1'b0;
                iSCLK = 1'b0;
            end
            @(negedge CLK);
            if (oVALID === 1'b1) begin
                obs_vcnt++;
                obs_bit = oBIT; obs_mask = oMASK; obs_phase = oPHASE;
                obs_lock = oLOCK; obs_err = oERR; obs_vcyc = cyc;
            end
            if (oERR === 1'b1) obs_ecnt++;
        end
        model_decode(b);
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        iCLK = 1'b0;
        iSCLK = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        vec++;
        if ({oVALID, oBIT, oMASK, oPHASE, oLOCK, oERR} !== 24'h0)
            $display("FAIL reset_outputs: got %h want 000000", {oVALID, oBIT, oMASK, oPHASE, oLOCK, oERR});
    endtask

    task automatic test_gate_disabled();
        int first;
        apply_reset();
        first = -1;
        for (int i = 0; i < 80; i++) begin
            do_pulse(1'b1);
            vec++;
            if (obs_vcnt !== 1 || obs_bit !== e_bit) begin
                bad++;
                $display("FAIL gate_bit[%0d]: got cnt=%0d bit=%b want cnt=1 bit=%b", i, obs_vcnt, obs_bit, e_bit);
            end
            vec++;
            if (obs_lock !== e_lock) begin
                bad++;
                $display("FAIL gate_lock[%0d]: got %b want %b", i, obs_lock, e_lock);
            end
            if (obs_lock === 1'b1 && first < 0) first = i;
        end
        vec++;
        if (first !== 79) begin
            bad++;
            $display("FAIL gate_lock_index: got %0d want 79", first);
        end
        vec++;
        if (obs_mask !== 16'hFFFF) begin
            bad++;
            $display("FAIL gate_mask: got %h want ffff", obs_mask);
        end
    endtask

    task automatic test_pattern();
        int first;
        bit rot_ok;
        logic [15:0] r;
        apply_reset();
        pk = 0;
        first = -1;
        for (int i = 0; i < 96; i++) begin
            do_pulse(pat_bit(pk));
            pk++;
            vec++;
            if (obs_vcnt !== 1 || obs_bit !== e_bit || obs_mask !== e_mask || obs_phase !== e_phase) begin
                bad++;
                $display("FAIL pat_data[%0d]: got cnt=%0d bit=%b mask=%h ph=%0d want bit=%b mask=%h ph=%0d",
                         i, obs_vcnt, obs_bit, obs_mask, obs_phase, e_bit, e_mask, e_phase);
            end
            vec++;
            if (obs_lock !== e_lock || obs_ecnt !== int'(e_err)) begin
                bad++;
                $display("FAIL pat_lock[%0d]: got lock=%b errs=%0d want lock=%b errs=%0d",
                         i, obs_lock, obs_ecnt, e_lock, e_err);
            end
            if (obs_lock === 1'b1 && first < 0) first = i;
        end
        vec++;
        if (first !== 79) begin
            bad++;
            $display("FAIL pat_lock_index: got %0d want 79", first);
        end
        rot_ok = 1'b0;
        r = PAT;
        for (int k = 0; k < 16; k++) begin
            if (obs_mask === r) rot_ok = 1'b1;
            r = {r[14:0], r[15]};
        end
        vec++;
        if (!rot_ok) begin
            bad++;
            $display("FAIL pat_rotation: got %h want a rotation of 3445", obs_mask);
        end
    endtask

    task automatic test_error();
        int relock;
        do_pulse(~pat_bit(pk));
        pk++;
        vec++;
        if (obs_err !== 1'b1 || obs_ecnt !== 1 || obs_lock !== 1'b0 || e_err !== 1'b1) begin
            bad++;
            $display("FAIL err_flip: got err=%b errs=%0d lock=%b want err=1 errs=1 lock=0",
                     obs_err, obs_ecnt, obs_lock);
        end
        relock = -1;
        for (int i = 1; i <= 84; i++) begin
            do_pulse(pat_bit(pk));
            pk++;
            vec++;
            if (obs_lock !== e_lock || obs_ecnt !== int'(e_err) || obs_mask !== e_mask) begin
                bad++;
                $display("FAIL err_follow[%0d]: got lock=%b errs=%0d mask=%h want lock=%b errs=%0d mask=%h",
                         i, obs_lock, obs_ecnt, obs_mask, e_lock, e_err, e_mask);
            end
            if (obs_lock === 1'b1 && relock < 0) relock = i;
        end
        vec++;
        if (relock !== 80) begin
            bad++;
            $display("FAIL err_relock: got offset %0d want 80", relock);
        end
    endtask

    task automatic test_timeout();
        int drop, errs, first;
        vec++;
        if (obs_lock !== 1'b1) begin
            bad++;
            $display("FAIL to_prelock: got %b want 1", obs_lock);
        end
        drop = -1;
        errs = 0;
        for (int i = 0; i < 1100 && drop < 0; i++) begin
            @(negedge CLK);
            if (oERR === 1'b1) errs++;
            if (oLOCK !== 1'b1) drop = cyc - obs_vcyc;
        end
        vec++;
        if (drop !== 1024 || errs !== 0) begin
            bad++;
            $display("FAIL to_drop: got delay=%0d errs=%0d want delay=1024 errs=0", drop, errs);
        end
        vec++;
        if (oMASK !== e_mask) begin
            bad++;
            $display("FAIL to_mask_kept: got %h want %h", oMASK, e_mask);
        end
        model_timeout();
        first = -1;
        for (int i = 0; i < 82; i++) begin
            do_pulse(pat_bit(pk));
            pk++;
            vec++;
            if (obs_lock !== e_lock || obs_ecnt !== int'(e_err) || obs_phase !== e_phase) begin
                bad++;
                $display("FAIL to_restart[%0d]: got lock=%b errs=%0d ph=%0d want lock=%b errs=%0d ph=%0d",
                         i, obs_lock, obs_ecnt, obs_phase, e_lock, e_err, e_phase);
            end
            if (obs_lock === 1'b1 && first < 0) first = i;
        end
        vec++;
        if (first !== 79) begin
            bad++;
            $display("FAIL to_relock_index: got %0d want 79", first);
        end
    endtask

    task automatic test_reset_mid();
        int vcnt;
        iCLK = 1'b1;
        iSCLK = 1'b1;
        repeat (2) @(negedge CLK);
        #3 RST_N = 1'b0;
        #1;
        vec++;
        if ({oVALID, oBIT, oMASK, oPHASE, oLOCK, oERR} !== 24'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got %h want 000000", {oVALID, oBIT, oMASK, oPHASE, oLOCK, oERR});
        end
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        iCLK = 1'b0;
        iSCLK = 1'b0;
        vcnt = 0;
        repeat (8) begin
            @(negedge CLK);
            if (oVALID === 1'b1) vcnt++;
        end
        vec++;
        if (vcnt !== 0) begin
            bad++;
            $display("FAIL rstmid_partial: got %0d pulses want 0", vcnt);
        end
        for (int i = 0; i < 20; i++) begin
            do_pulse(1'($urandom_range(0, 1)));
            vec++;
            if (obs_vcnt !== 1 || obs_bit !== e_bit || obs_mask !== e_mask || obs_phase !== e_phase || obs_lock !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_fill[%0d]: got bit=%b mask=%h ph=%0d lock=%b want bit=%b mask=%h ph=%0d lock=0",
                         i, obs_bit, obs_mask, obs_phase, obs_lock, e_bit, e_mask, e_phase);
            end
        end
    endtask

    task automatic test_latency();
        bit b;
        logic v1, v2, v3, lb;
        logic [3:0] lp;
        b = 1'($urandom_range(0, 1));
        iCLK = 1'b1;
        iSCLK = b;
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #2;
        iCLK = 1'b0;
        iSCLK = 1'b0;
        @(posedge CLK); #1 v1 = oVALID;
        @(posedge CLK); #1 v2 = oVALID;
        @(posedge CLK); #1 v3 = oVALID;
        lb = oBIT;
        lp = oPHASE;
        repeat (4) @(negedge CLK);
        model_decode(b);
        vec++;
        if ({v1, v2, v3} !== 3'b001) begin
            bad++;
            $display("FAIL latency: got %b%b%b want 001", v1, v2, v3);
        end
        vec++;
        if (lb !== e_bit || lp !== e_phase) begin
            bad++;
            $display("FAIL latency_data: got bit=%b ph=%0d want bit=%b ph=%0d", lb, lp, e_bit, e_phase);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time %0t want completion", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_gate_disabled();
        test_pattern();
        test_error();
        test_timeout();
        test_reset_mid();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
